multiword_add_seq: RTL and testbench

- Multi-cycle, multi-precision add/subtract sequencer that reuses one WIDTH-bit ripple-carry adder slice.
- Computes an NWORDS×WIDTH-bit result, one word per cycle, least-significant word first, holding the inter-word carry in a register.
- Sits between an operand producer and a result consumer; valid/ready handshakes on both sides.
- Lets the design process wide operands without instantiating a wide adder.

---
 rtl/multiword_add_seq.sv | 169 ++++++++++++++++
 tb/tb_multiword_add_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_seq.sv
// Multi-precision add/subtract sequencer: one WIDTH-bit ripple slice is reused
// NWORDS times, least-significant word first, with the inter-word carry held in a register.

module multiword_add_seq_slice #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ci,
  output logic [WIDTH-1:0] o_s,
  output logic             o_co
);

  logic w_c;

  always_comb begin
    o_s = '0;
    // NOTE: blocking assignments inside always_comb let w_c ripple bit to bit
    // within one evaluation; non-blocking here would sample the stale carry.
    w_c = i_ci;
    for (int i = 0; i < WIDTH; i++) begin
      o_s[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c    = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_co = w_c;
  end

endmodule

module multiword_add_seq #(
  parameter int WIDTH  = 4,
  parameter int NWORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NWORDS*WIDTH-1:0]  a_in,
  input  logic [NWORDS*WIDTH-1:0]  b_in,
  input  logic                     sub_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NWORDS*WIDTH-1:0]  sum_o,
  output logic                     carry_o,
  output logic                     ovf_o,
  output logic                     busy_o
);

  localparam int N  = NWORDS * WIDTH;
  localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [KW-1:0]   r_k;
  logic            r_carry;
  logic            r_armed;
  logic [N-1:0]    r_op_a;
  logic [N-1:0]    r_op_b;
  logic [N-1:0]    r_sum;
  logic            r_carry_o;
  logic            r_ovf;

  logic            w_accept;
  logic            w_last;
  logic [WIDTH-1:0] w_a_word;
  logic [WIDTH-1:0] w_b_word;
  logic [WIDTH-1:0] w_sum_word;
  logic            w_co;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy_o    = (r_state == ST_RUN);
  assign sum_o     = r_sum;
  assign carry_o   = r_carry_o;
  assign ovf_o     = r_ovf;

  // r_armed is low on the edge that releases reset, so no operand is taken there.
  assign w_accept = in_valid && in_ready && r_armed;
  assign w_last   = (r_k == KW'(NWORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_armed <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_a_word = '0;
    w_b_word = '0;
    for (int w = 0; w < NWORDS; w++) begin
      if (r_k == KW'(w)) begin
        w_a_word = r_op_a[w*WIDTH +: WIDTH];
        w_b_word = r_op_b[w*WIDTH +: WIDTH];
      end
    end
  end

  multiword_add_seq_slice #(.WIDTH(WIDTH)) u_slice (
    .i_a  (w_a_word),
    .i_b  (w_b_word),
    .i_ci (r_carry),
    .o_s  (w_sum_word),
    .o_co (w_co)
  );

  // NOTE: operand registers carry no reset; they are always loaded on accept
  // before the slice reads them, and leaving them out of reset keeps them plain flops.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op_a <= a_in;
      r_op_b <= sub_in ? ~b_in : b_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k       <= '0;
      r_carry   <= 1'b0;
      r_sum     <= '0;
      r_carry_o <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_k     <= '0;
            r_carry <= sub_in;
          end
        end
        ST_RUN: begin
          for (int w = 0; w < NWORDS; w++) begin
            if (r_k == KW'(w)) r_sum[w*WIDTH +: WIDTH] <= w_sum_word;
          end
          r_carry <= w_co;
          if (w_last) begin
            // Subtract already holds ~B in r_op_b, so the same sign test covers both ops.
            r_carry_o <= w_co;
            r_ovf     <= (r_op_a[N-1] == r_op_b[N-1]) &&
                         (w_sum_word[WIDTH-1] != r_op_a[N-1]);
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq at WIDTH=4, NWORDS=4 with hand-computed results.

module tb_multiword_add_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        sub_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum_o;
  logic        carry_o;
  logic        ovf_o;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  multiword_add_seq #(.WIDTH(4), .NWORDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .sub_in    (sub_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_o     (sum_o),
    .carry_o   (carry_o),
    .ovf_o     (ovf_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for busy_o to rise, i.e. the accept edge has passed.
  task automatic wait_accept(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy_o) begin ok = 1'b1; break; end
    end
    if (!ok) check({tag, "_accept_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string tag, output int lat);
    bit ok = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [15:0] es, input logic ec, input logic eo);
    bit ok;
    int lat;
    @(negedge clk);
    a_in = a; b_in = b; sub_in = s; in_valid = 1'b1; out_ready = 1'b1;
    wait_accept(tag, ok);
    in_valid = 1'b0;
    if (!ok) return;
    wait_done(tag, lat);
    check({tag, "_latency"}, lat, 4);
    check({tag, "_sum"},     sum_o, es);
    check({tag, "_carry"},   carry_o, ec);
    check({tag, "_ovf"},     ovf_o, eo);
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
  endtask

  logic [15:0] bb_a   [3] = '{16'h0F0F, 16'h1000, 16'hFFFE};
  logic [15:0] bb_b   [3] = '{16'h0101, 16'h0001, 16'hFFFE};
  logic        bb_s   [3] = '{1'b0, 1'b1, 1'b0};
  logic [15:0] bb_sum [3] = '{16'h1010, 16'h0FFF, 16'hFFFC};
  logic        bb_c   [3] = '{1'b0, 1'b1, 1'b1};
  int          acc    [3];

  initial begin
    bit ok;
    int lat;
    int pulses;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0; sub_in = 1'b0;
    #2;
    check("rst_in_ready",  in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy",      busy_o, 0);
    check("rst_sum",       sum_o, 0);
    check("rst_carry",     carry_o, 0);
    check("rst_ovf",       ovf_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("add_00ff", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    do_op("add_ffff", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("add_7fff", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("sub_5_7",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_7_5",  16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
    do_op("sub_8000", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Backpressure with a competing request during DONE.
    @(negedge clk);
    a_in = 16'h1111; b_in = 16'h2222; sub_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    wait_accept("bp", ok);
    in_valid = 1'b0;
    wait_done("bp", lat);
    @(negedge clk);
    a_in = 16'hAAAA; b_in = 16'h5555; sub_in = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_sum",      sum_o, 16'h3333);
      check("bp_carry",    carry_o, 0);
      check("bp_ovf",      ovf_o, 0);
      check("bp_valid",    out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_valid_drop", out_valid, 0);
    check("bp_ready_back", in_ready, 1);
    check("bp_no_accept",  busy_o, 0);

    // Reset in the middle of RUN at k=2.
    @(negedge clk);
    a_in = 16'h1234; b_in = 16'h1111; sub_in = 1'b0; in_valid = 1'b1;
    wait_accept("mrst", ok);
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("mrst_sum",      sum_o, 0);
    check("mrst_busy",     busy_o, 0);
    check("mrst_valid",    out_valid, 0);
    check("mrst_in_ready", in_ready, 1);
    check("mrst_carry",    carry_o, 0);
    in_valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mrst_no_pulse",       pulses, 0);
    check("mrst_release_no_acc", busy_o, 0);
    do_op("mrst_rerun", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

    // Back-to-back with in_valid and out_ready held high.
    @(negedge clk);
    a_in = bb_a[0]; b_in = bb_b[0]; sub_in = bb_s[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_accept("b2b", ok);
      acc[i] = cyc;
      if (i < 2) begin
        a_in = bb_a[i+1]; b_in = bb_b[i+1]; sub_in = bb_s[i+1];
      end else begin
        in_valid = 1'b0;
      end
      wait_done("b2b", lat);
      check("b2b_sum",   sum_o, bb_sum[i]);
      check("b2b_carry", carry_o, bb_c[i]);
      check("b2b_ovf",   ovf_o, 0);
      if (i > 0) check("b2b_spacing", acc[i] - acc[i-1], 6);
    end
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
